serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to add a and b; sampled only when ready=1.
REQ-005 a  input  WIDTH  operand A; captured on an accepted start.
REQ-006 b  input  WIDTH  operand B; captured on an accepted start.
REQ-007 ready  output  1  high in IDLE and DONE, meaning start will be accepted.
REQ-008 busy  output  1  high in RUN.
REQ-009 done  output  1  one-cycle pulse marking a valid new result.
REQ-010 sum  output  WIDTH  result bits, valid from the done cycle onward.
REQ-011 cout  output  1  carry out of bit WIDTH-1, valid with sum.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b, an unsigned (WIDTH+1)-bit result, LSB-first over WIDTH cycles using one shared full-adder slice.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE to RUN on start.
- RUN to DONE when the bit counter reaches WIDTH-1.
- DONE to RUN on start.
- DONE to IDLE otherwise.
REQ-014 An accepted start SHALL do all of the following:
- latch a and b into shift registers;
- clear the carry flop;
- clear the bit counter, which is ceil(log2(WIDTH)) bits wide;
- clear the result shift register.
REQ-015 Each RUN cycle SHALL do all of the following:
- feed operand LSBs and the carry flop into the slice;
- shift the slice sum into the result register MSB, with the register shifting right;
- update the carry flop;
- shift both operand registers right;
- increment the counter.
REQ-016 Latency: if start is sampled at edge k, RUN SHALL occupy cycles k+1..k+WIDTH, and done SHALL be high only in cycle k+WIDTH+1.
REQ-017 sum and cout SHALL update only on the edge that enters DONE, and SHALL hold until the next completion or reset.
REQ-018 start SHALL be ignored while busy=1, with no effect on the operation in flight.
REQ-019 Changes on a and b SHALL have no effect after capture.
REQ-020 A start sampled in the DONE cycle SHALL be accepted, giving back-to-back operations with one cycle of done between them.
REQ-021 done, busy and ready SHALL be decoded from state alone, which makes them mutually consistent (ready = !busy).
REQ-022 A carry out of the final bit SHALL appear only on cout; it SHALL never wrap into sum[0].

Reset
REQ-023 When rst=1 at a rising edge, the block SHALL enter IDLE and clear every register: operands, result, carry, counter, sum and cout.
REQ-024 After reset the outputs SHALL be ready=1, busy=0, done=0, sum=0 and cout=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; rst SHALL take priority over start in the same cycle.

Structure
REQ-026 A shared package serial_add_pkg SHALL hold two items:
- the state enum (IDLE/RUN/DONE, 2-bit encoding);
- the constant SERIAL_ADD_WIDTH_DEFAULT = 8.
REQ-027 The bit slice SHALL be the existing half_adder primitive, used through one sub-module full_adder (a, b, cin -> sum, cout).
- full_adder SHALL be built from two half_adder instances plus an OR of their carries.
- full_adder SHALL be instantiated exactly once in serial_add_ctrl.
REQ-028 The block SHALL contain no combinational path from inputs to outputs.

Verification (WIDTH=8)
REQ-029 The bench SHALL cover these directed scenarios:
- 0x00 + 0x00, start one cycle -> done 9 cycles later, sum=0x00, cout=0.
- 0xFF + 0x01 -> carry ripples through every bit; done in cycle 9, sum=0x00, cout=1.
- 0xA5 + 0x5A, with a and b driven to 0x00 one cycle after start -> sum=0xFF, cout=0; the late operand change has no effect.
- start pulsed in RUN cycle 3 with new operands -> ignored; the first result is correct and exactly one done pulse occurs.
- rst asserted in RUN cycle 4 -> IDLE next cycle, no done pulse, sum=0, cout=0, ready=1.
- Back-to-back: 0x80+0x80 then start in the DONE cycle with 0x7F+0x01 -> first result sum=0x00, cout=1; second result sum=0x80, cout=0, 9 cycles after the first done.
REQ-030 The bench SHALL also run a randomized sweep of at least 1000 operand pairs, compared against a + b, and SHALL end with $fatal on any mismatch.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: controller states and default width.
package serial_add_pkg;
    localparam int SERIAL_ADD_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/full_adder.sv
// Full-adder bit slice composed from two half adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .cout(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .cout(c1));

    assign cout = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// Single-bit half adder primitive.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: one shared full-adder slice walks the operands LSB-first
// over WIDTH cycles; the result is published on entry to DONE.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    // Holds the WIDTH-1 bits already produced; the final bit joins them on the last RUN edge.
    logic [WIDTH-2:0]   res_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   res_d;

    full_adder u_slice (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign res_d = {fa_sum, res_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        a_q     <= a;
                        b_q     <= b;
                        res_q   <= '0;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    res_q   <= res_d[WIDTH-1:1];
                    carry_q <= fa_cout;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        sum_q   <= res_d;
                        cout_q  <= fa_cout;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = (state_q == RUN);
    assign ready = !busy;
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed vector table, multi-cycle corner sequences and a random sweep for serial_add_ctrl.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Waits up to limit negedges for done; returns limit+1 on timeout.
    task automatic wait_done(input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Launches one add; lat counts cycles from the start edge to the done cycle.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input bit scramble,
                          output logic [7:0] s, output logic c, output int lat);
        int n;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            a = 8'h00;
            b = 8'h00;
        end
        chk("busy_first_run_cycle", 32'(busy), 32'd1);
        wait_done(20, n);
        lat = n + 1;
        s = sum;
        c = cout;
    endtask

    initial begin
        logic [7:0] s;
        logic       c;
        int         lat;
        int         n;
        int         pulses;
        int         first;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] rexp;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[3] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[5] = '{8'h01, 8'h01, 8'h02, 1'b0};
        vecs[6] = '{8'h55, 8'hAA, 8'hFF, 1'b0};
        vecs[7] = '{8'h0F, 8'h01, 8'h10, 1'b0};
        vecs[8] = '{8'hC3, 8'h3C, 8'hFF, 1'b0};
        vecs[9] = '{8'h99, 8'h77, 8'h10, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);
        chk("reset_sum",   32'(sum),   32'd0);
        chk("reset_cout",  32'(cout),  32'd0);
        $display("reset: ready=%0b busy=%0b done=%0b sum=%02h cout=%0b", ready, busy, done, sum, cout);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].va, vecs[i].vb, 1'b0, s, c, lat);
            chk("vec_sum",     32'(s),   32'(vecs[i].s));
            chk("vec_cout",    32'(c),   32'(vecs[i].c));
            chk("vec_latency", 32'(lat), 32'd9);
            @(negedge clk);
            chk("vec_done_single", 32'(done), 32'd0);
            $display("vec %0d: %02h + %02h -> sum=%02h cout=%0b lat=%0d", i, vecs[i].va, vecs[i].vb, s, c, lat);
        end

        // Operands dropped to zero right after capture.
        run_op(8'hA5, 8'h5A, 1'b1, s, c, lat);
        chk("late_change_sum",  32'(s),   32'hFF);
        chk("late_change_cout", 32'(c),   32'd0);
        chk("late_change_lat",  32'(lat), 32'd9);
        $display("late change: A5 + 5A -> sum=%02h cout=%0b lat=%0d", s, c, lat);

        // Second start in RUN cycle 3 must be ignored.
        @(negedge clk);
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        first = 0;
        s = '0;
        c = 1'b0;
        for (int k = 5; k <= 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first = k;
                    s = sum;
                    c = cout;
                end
            end
        end
        chk("ignored_start_pulses", 32'(pulses), 32'd1);
        chk("ignored_start_lat",    32'(first),  32'd9);
        chk("ignored_start_sum",    32'(s),      32'h46);
        chk("ignored_start_cout",   32'(c),      32'd0);
        chk("sum_holds",            32'(sum),    32'h46);
        $display("ignored start: 12 + 34 -> sum=%02h cout=%0b pulses=%0d lat=%0d", s, c, pulses, first);

        // Reset in RUN cycle 4 after a non-zero result.
        run_op(8'hFF, 8'hFF, 1'b0, s, c, lat);
        chk("pre_reset_sum", 32'(s), 32'hFE);
        @(negedge clk);
        a = 8'h33;
        b = 8'h44;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_ready", 32'(ready), 32'd1);
        chk("midrun_rst_busy",  32'(busy),  32'd0);
        chk("midrun_rst_done",  32'(done),  32'd0);
        chk("midrun_rst_sum",   32'(sum),   32'd0);
        chk("midrun_rst_cout",  32'(cout),  32'd0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("midrun_rst_no_done", 32'(pulses), 32'd0);
        $display("midrun reset: ready=%0b sum=%02h cout=%0b done_pulses=%0d", ready, sum, cout, pulses);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_priority_busy", 32'(busy), 32'd0);
        $display("reset priority: busy=%0b", busy);

        // Back-to-back: restart in the DONE cycle.
        run_op(8'h80, 8'h80, 1'b0, s, c, lat);
        chk("b2b_first_sum",  32'(s),   32'h00);
        chk("b2b_first_cout", 32'(c),   32'd1);
        chk("b2b_first_lat",  32'(lat), 32'd9);
        a = 8'h7F;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_restart_busy", 32'(busy), 32'd1);
        wait_done(20, n);
        chk("b2b_second_gap",  32'(n + 1), 32'd9);
        chk("b2b_second_sum",  32'(sum),   32'h80);
        chk("b2b_second_cout", 32'(cout),  32'd0);
        $display("back-to-back: 80+80 then 7F+01 -> sum=%02h cout=%0b gap=%0d", sum, cout, n + 1);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb};
            run_op(ra, rb, 1'b0, s, c, lat);
            chk("rand_result",  32'({c, s}), 32'(rexp));
            chk("rand_latency", 32'(lat),    32'd9);
            $display("rand %0d: %02h + %02h -> %03h", i, ra, rb, {c, s});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        if (errors != 0) $fatal(1, "serial adder bench saw %0d errors", errors);
        $finish;
    end
endmodule
